instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 98 +++++++++
 tb/tb_instr_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a small program buffer and hands one
// instruction at a time to the decoder over a valid/ready handshake.
module instr_sequencer #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_data,
    input  logic          start,
    input  logic          dec_ready,
    output logic [17:0]   id,
    output logic          id_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          overrun,
    output logic [7:0]    issue_cnt
);

    localparam logic [4:0]    OP_HALT = 5'b10001;
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    state_t      state;
    logic [17:0] mem [DEPTH];
    logic        parked;

    assign parked = (state == IDLE) || (state == HALT);

    // Program storage is deliberately left out of reset so a reset does not wipe the program.
    always_ff @(posedge clk) begin
        if (prog_we && parked) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            id        <= '0;
            id_valid  <= 1'b0;
            pc        <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            overrun   <= 1'b0;
            issue_cnt <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        pc        <= '0;
                        issue_cnt <= '0;
                        halted    <= 1'b0;
                        overrun   <= 1'b0;
                    end
                end
                FETCH: begin
                    id       <= mem[pc];
                    id_valid <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (dec_ready) begin
                        id_valid <= 1'b0;
                        if (issue_cnt != 8'hFF) begin
                            issue_cnt <= issue_cnt + 8'd1;
                        end
                        if (id[17:13] == OP_HALT) begin
                            halted <= 1'b1;
                            busy   <= 1'b0;
                            state  <= HALT;
                        end else if (pc == LAST_PC) begin
                            // Falling off the end of the buffer parks the run with the overrun flag.
                            pc      <= '0;
                            overrun <= 1'b1;
                            busy    <= 1'b0;
                            state   <= HALT;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [17:0] W0 = 18'b110010000011011000;
    localparam logic [17:0] W1 = 18'b101101110011101100;
    localparam logic [17:0] W2 = 18'b000110001111001100;
    localparam logic [17:0] W3 = 18'b100010111011001100;
    localparam logic [4:0]  OP_HALT = 5'b10001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [17:0]   prog_data = '0;
    logic          start = 1'b0;
    logic          dec_ready = 1'b0;
    logic [17:0]   id;
    logic          id_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          overrun;
    logic [7:0]    issue_cnt;

    int tests = 0;
    int fails = 0;

    logic [17:0] seen [$];
    logic [17:0] words [DEPTH];

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .dec_ready(dec_ready), .id(id),
        .id_valid(id_valid), .pc(pc), .busy(busy), .halted(halted),
        .overrun(overrun), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: m_phase 0 = parked (idle or halted), 1 = fetch pending, 2 = presenting.
    logic [17:0] prog [DEPTH];
    int          m_phase = 0;
    logic [17:0] m_id = '0;
    bit          m_valid = 0;
    int          m_pc = 0;
    bit          m_halted = 0;
    bit          m_overrun = 0;
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_id = '0; m_valid = 0; m_pc = 0;
            m_halted = 0; m_overrun = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (prog_we) prog[prog_addr] = prog_data;
            if (start) begin
                m_phase = 1; m_pc = 0; m_cnt = 0; m_halted = 0; m_overrun = 0;
            end
        end else if (m_phase == 1) begin
            m_id = prog[m_pc];
            m_valid = 1;
            m_phase = 2;
        end else if (dec_ready) begin
            m_valid = 0;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (m_id[17:13] == OP_HALT) begin
                m_halted = 1;
                m_phase = 0;
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
                if (m_pc == 0) begin
                    m_overrun = 1;
                    m_phase = 0;
                end else begin
                    m_phase = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        tests++;
        if (id !== m_id || id_valid !== m_valid || pc !== AW'(m_pc) || busy !== (m_phase != 0) ||
            halted !== m_halted || overrun !== m_overrun || issue_cnt !== 8'(m_cnt)) begin
            fails++;
            $display("[TB] FAIL cycle_compare t=%0t got/exp id=%h/%h valid=%b/%b pc=%0d/%0d busy=%b/%b halted=%b/%b overrun=%b/%b cnt=%0d/%0d",
                     $time, id, m_id, id_valid, m_valid, pc, m_pc, busy, (m_phase != 0),
                     halted, m_halted, overrun, m_overrun, issue_cnt, m_cnt);
        end
    end

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [17:0] data,
                                 input logic st, input logic rdy);
        @(negedge clk);
        prog_we = we; prog_addr = addr; prog_data = data; start = st; dec_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadProgram();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, AW'(i), words[i], 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Holds dec_ready high and records every accepted word until the run parks.
    task automatic collect(input int budget);
        seen.delete();
        for (int c = 0; c < budget && m_phase != 0; c++) begin
            if (id_valid && dec_ready) seen.push_back(id);
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checkOutput("run_terminated", 32'(m_phase == 0), 32'd1);
    endtask

    task automatic runProgram(input int budget);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        collect(budget);
    endtask

    task automatic checkBasicRun(input string tag);
        checkOutput({tag, "_count"}, 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            checkOutput({tag, "_w0"}, 32'(seen[0]), 32'(W0));
            checkOutput({tag, "_w1"}, 32'(seen[1]), 32'(W1));
            checkOutput({tag, "_w2"}, 32'(seen[2]), 32'(W2));
            checkOutput({tag, "_w3"}, 32'(seen[3]), 32'(W3));
        end
        checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
        checkOutput({tag, "_pc"}, 32'(pc), 32'd3);
        checkOutput({tag, "_cnt"}, 32'(issue_cnt), 32'd4);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [17:0] w;
        repeat (3) @(negedge clk);
        checkOutput("reset_id", 32'(id), 32'd0);
        checkOutput("reset_valid", 32'(id_valid), 32'd0);
        checkOutput("reset_pc", 32'(pc), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_flags", {30'd0, halted, overrun}, 32'd0);
        checkOutput("reset_cnt", 32'(issue_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic four-word program ending in HALT.
        for (int i = 0; i < DEPTH; i++) words[i] = '0;
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
        loadProgram();
        runProgram(40);
        checkBasicRun("basic");

        // Restart from HALT, then stall the decoder on word 1.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("restart_halted_clear", 32'(halted), 32'd0);
        checkOutput("restart_cnt", 32'(issue_cnt), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("restart_id", 32'(id), 32'(W0));
        checkOutput("restart_valid", 32'(id_valid), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
            checkOutput("stall_id", 32'(id), 32'(W1));
            checkOutput("stall_valid", 32'(id_valid), 32'd1);
            checkOutput("stall_pc", 32'(pc), 32'd1);
        end
        collect(40);
        checkOutput("stall_cnt", 32'(issue_cnt), 32'd4);
        checkOutput("stall_halted", 32'(halted), 32'd1);

        // Write and start while busy must be ignored.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, AW'(2), 18'h3FFFF, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        collect(40);
        checkBasicRun("busy_write");

        // Reset while presenting pc=2 aborts immediately; next start reruns from 0.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 40 && !(m_phase == 2 && m_pc == 2); c++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(id_valid), 32'd0);
        checkOutput("abort_pc", 32'(pc), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runProgram(40);
        checkBasicRun("after_abort");

        // Same-cycle write to address 0 and start: first fetch sees the new word.
        w = {OP_HALT, 13'h0A5};
        applyStimulus(1'b1, '0, w, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        collect(40);
        checkOutput("wr_start_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) checkOutput("wr_start_word", 32'(seen[0]), 32'(w));
        checkOutput("wr_start_cnt", 32'(issue_cnt), 32'd1);

        // Program without HALT runs off the end.
        for (int i = 0; i < DEPTH; i++) words[i] = W0;
        loadProgram();
        runProgram(80);
        checkOutput("overrun_flag", 32'(overrun), 32'd1);
        checkOutput("overrun_halted", 32'(halted), 32'd0);
        checkOutput("overrun_pc", 32'(pc), 32'd0);
        checkOutput("overrun_cnt", 32'(issue_cnt), 32'd16);
        checkOutput("overrun_seen", 32'(seen.size()), 32'd16);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < DEPTH; i++) begin
            w = 18'($urandom);
            if ($urandom_range(0, 3) == 0) w[17:13] = OP_HALT;
            words[i] = w;
        end
        loadProgram();
        for (int c = 0; c < 3000; c++) begin
            w = 18'($urandom);
            if ($urandom_range(0, 5) == 0) w[17:13] = OP_HALT;
            applyStimulus($urandom_range(0, 3) == 0, AW'($urandom), w,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
